xo_board_painter: RTL and testbench
===================================

Name: xo_board_painter

Overview:
- Parametrised N×N tic-tac-toe board glyph renderer for the VGA text path.
- Maps pixel coordinates to board cells and drives font ROM addresses for 'X', 'O', cursor and conflict glyphs.
- Produces registered, pixel-aligned text_rgb with a blinking win highlight and a cursor highlight.
- Sits between the VGA sync generator / external font ROM and the final RGB mux.

Parameters:
- GRID_N, 3, cells per side (2..4).
- SCALE_SHIFT, 2, glyph scale: each 8×16 font pixel is 2^SCALE_SHIFT square screen pixels.
- ORIGIN_X, 192, board left edge in pixels.
- ORIGIN_Y, 384, board top edge in pixels.
- BLINK_BIT, 4, frame-counter bit used as blink phase.
- FG_RGB, 3'b111, glyph colour.
- BG_RGB, 3'b000, cell background colour.
- WIN_RGB, 3'b010, winning-glyph colour in blink-on phase.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- pixel_tick  in  1  pixel enable; at least 2 clk apart
- pix_x  in  10  current pixel column
- pix_y  in  10  current pixel row
- frame_tick  in  1  one-clk pulse at start of vertical blank
- x_matrix  in  GRID_N*GRID_N  bit i set = X in cell i (row-major)
- o_matrix  in  GRID_N*GRID_N  bit i set = O in cell i
- win_mask  in  GRID_N*GRID_N  winning-line cells
- cursor_en  in  1  enable cursor highlight
- cursor_idx  in  4  selected cell index
- char_addr  out  7  font ROM character code
- row_addr  out  4  font ROM glyph row
- bit_addr  out  3  font ROM glyph column
- font_bit  in  1  font ROM data; valid 1 clk after address
- xo_on  out  1  registered: board pixel being driven
- text_rgb  out  3  registered pixel colour

Behaviour:
- Reset (async, active-low): all outputs 0, shadow registers 0, frame counter 0, pipeline valid bits 0.
- Shadow registers: x_matrix, o_matrix, win_mask, cursor_en and cursor_idx are captured on frame_tick only, so the board never tears mid-frame.
- Geometry, with dx = pix_x − ORIGIN_X and dy = pix_y − ORIGIN_Y (unsigned; negative means outside the board):
  - Cell pitch is 16<<S in x and 16<<S in y, where S = SCALE_SHIFT.
  - The glyph occupies the left half of each cell in x (8<<S wide), so the right half is a gap.
  - col = dx>>(S+4); row = dy>>(S+4).
  - In-glyph when col<GRID_N, row<GRID_N and dx bit (S+3) = 0.
  - idx = row*GRID_N + col.
  - row_addr = (dy>>S)[3:0]; bit_addr = (dx>>S)[2:0].
- Character select per cell:
  - X only → 7'h58.
  - O only → 7'h4F.
  - Both set → 7'h3F ('?', conflict).
  - Neither set → 7'h5F ('_') if this is the cursor cell, else 7'h20.
  - Cursor cell means cursor_en=1 and cursor_idx=idx; cursor_idx ≥ GRID_N² means no cursor.
- Pipeline, advancing only on pixel_tick:
  - Stage 1 registers char_addr, row_addr, bit_addr, plus in_glyph, win and cursor flags.
  - Stage 2, on the next pixel_tick, samples font_bit and registers xo_on and text_rgb.
  - Total latency is 2 pixel_ticks; outputs hold between ticks.
- Colour resolution (stage 2):
  - Not in_glyph → xo_on=0, text_rgb=3'b000.
  - Otherwise fg = WIN_RGB if win and blink=1, else FG_RGB. blink = frame_cnt[BLINK_BIT].
  - Cursor cell swaps fg and BG_RGB.
  - text_rgb = font_bit ? fg : bg.
- Frame counter: 5-bit, increments on frame_tick, wraps 31→0.
- Simultaneous pixel_tick and frame_tick: both actions occur. The pipeline uses the pre-capture shadow values.

Optional Feature:
- Macro XO_GRID_LINES_EN.
- Defined: inside the board bounding box (col<GRID_N, row<GRID_N), pixels with dx[S+3:0]==0 or dy[S+3:0]==0 are driven 3'b001 with xo_on=1.
  - Glyph foreground wins over grid colour; grid colour wins over glyph background.
- Undefined: no grid logic; those pixels follow the normal rules.

Test Plan:
1. Reset low mid-frame, then release → text_rgb=000, xo_on=0, char_addr=0. First frame_tick then captures the inputs.
2. x_matrix=9'b000000001, frame_tick, pixel (192,384) then (224,384) → char_addr=58h at the first pixel, 20h at (224,384). text_rgb follows font_bit 2 pixel_ticks later.
3. x_matrix bit 4 and o_matrix bit 4 both set → cell 4 at pixel (256,448) gives char_addr=3Fh; o_matrix bit 8 alone → cell 8 gives 4Fh.
4. win_mask=9'b100010001, 32 frame_ticks → cells 0, 4 and 8 are FG_RGB during frames 0–15 and WIN_RGB during 16–31; other cells stay FG_RGB.
5. cursor_en=1, cursor_idx=5 on an empty board → char_addr=5Fh, font_bit=0 gives 111, font_bit=1 gives 000. cursor_idx=12 → no highlight.
6. Change x_matrix mid-frame without frame_tick → output unchanged until the next frame_tick.

Source files
------------

// File: rtl/xo_board_painter_if.sv
// Font ROM lookup bus between the board painter (master) and the character ROM (slave).
interface xo_board_painter_if;
  logic [6:0] char_addr;
  logic [3:0] row_addr;
  logic [2:0] bit_addr;
  logic       font_bit;

  modport master (output char_addr, row_addr, bit_addr, input font_bit);
  modport slave  (input char_addr, row_addr, bit_addr, output font_bit);
endinterface

// File: rtl/xo_board_painter.sv
// N x N tic-tac-toe glyph renderer: pixel -> cell -> font ROM address -> registered text_rgb.
// Optional grid-line overlay enabled by defining XO_GRID_LINES_EN.
module xo_board_painter #(
  parameter int unsigned GRID_N      = 3,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned ORIGIN_X    = 192,
  parameter int unsigned ORIGIN_Y    = 384,
  parameter int unsigned BLINK_BIT   = 4,
  parameter logic [2:0]  FG_RGB      = 3'b111,
  parameter logic [2:0]  BG_RGB      = 3'b000,
  parameter logic [2:0]  WIN_RGB     = 3'b010
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pixel_tick,
  input  logic [9:0]                 pix_x,
  input  logic [9:0]                 pix_y,
  input  logic                       frame_tick,
  input  logic [GRID_N*GRID_N-1:0]   x_matrix,
  input  logic [GRID_N*GRID_N-1:0]   o_matrix,
  input  logic [GRID_N*GRID_N-1:0]   win_mask,
  input  logic                       cursor_en,
  input  logic [3:0]                 cursor_idx,
  xo_board_painter_if.master         font,
  output logic                       xo_on,
  output logic [2:0]                 text_rgb
);

  localparam int unsigned NCELL     = GRID_N * GRID_N;
  localparam int unsigned CELL_SH   = SCALE_SHIFT + 4;
  localparam int unsigned GLYPH_BIT = SCALE_SHIFT + 3;

  logic [NCELL-1:0] x_sh, o_sh, win_sh;
  logic             cursor_en_sh;
  logic [3:0]       cursor_idx_sh;
  logic [4:0]       frame_cnt;

  logic             s1_valid, s1_in_glyph, s1_win, s1_cursor;
  logic [6:0]       char_q;
  logic [3:0]       row_q;
  logic [2:0]       bit_q;

  logic [9:0] dx_c, dy_c, col_c, row_c, idx_c;
  logic       in_box_c, in_glyph_c, cursor_c;
  logic       cell_x_c, cell_o_c, cell_w_c;
  logic [6:0] char_c;
  logic [2:0] fg_c, bg_c, rgb_c;
  logic       on_c;

  // Negative offsets wrap to large values and fall outside the board
  assign dx_c       = pix_x - 10'(ORIGIN_X);
  assign dy_c       = pix_y - 10'(ORIGIN_Y);
  assign col_c      = dx_c >> CELL_SH;
  assign row_c      = dy_c >> CELL_SH;
  assign in_box_c   = (col_c < 10'(GRID_N)) && (row_c < 10'(GRID_N));
  assign in_glyph_c = in_box_c && !dx_c[GLYPH_BIT];
  assign idx_c      = row_c * 10'(GRID_N) + col_c;
  assign cursor_c   = in_box_c && cursor_en_sh && (10'(cursor_idx_sh) == idx_c);

  // Cell contents lookup from the frame-stable shadow copy
  always_comb begin
    cell_x_c = 1'b0;
    cell_o_c = 1'b0;
    cell_w_c = 1'b0;
    for (int unsigned i = 0; i < NCELL; i++) begin
      if (in_box_c && (idx_c == 10'(i))) begin
        cell_x_c = x_sh[i];
        cell_o_c = o_sh[i];
        cell_w_c = win_sh[i];
      end
    end
  end

  // Gap and off-board pixels address the blank character
  always_comb begin
    char_c = 7'h20;
    if (in_glyph_c) begin
      unique case ({cell_x_c, cell_o_c})
        2'b10:   char_c = 7'h58;
        2'b01:   char_c = 7'h4F;
        2'b11:   char_c = 7'h3F;
        default: char_c = cursor_c ? 7'h5F : 7'h20;
      endcase
    end
  end

`ifdef XO_GRID_LINES_EN
  localparam logic [9:0] CELL_MASK = 10'((1 << CELL_SH) - 1);
  logic grid_c, s1_grid;
  assign grid_c = in_box_c && (((dx_c & CELL_MASK) == 10'd0) || ((dy_c & CELL_MASK) == 10'd0));
`endif

  // Stage 2 colour resolution; cursor swaps foreground and background
  always_comb begin
    fg_c  = (s1_win && frame_cnt[BLINK_BIT]) ? WIN_RGB : FG_RGB;
    bg_c  = BG_RGB;
    rgb_c = 3'b000;
    on_c  = 1'b0;
    if (s1_cursor) begin
      fg_c = BG_RGB;
      bg_c = (s1_win && frame_cnt[BLINK_BIT]) ? WIN_RGB : FG_RGB;
    end
    if (s1_valid && s1_in_glyph) begin
      on_c  = 1'b1;
      rgb_c = font.font_bit ? fg_c : bg_c;
    end
`ifdef XO_GRID_LINES_EN
    if (s1_valid && s1_grid && !(s1_in_glyph && font.font_bit)) begin
      on_c  = 1'b1;
      rgb_c = 3'b001;
    end
`endif
  end

  // Shadow capture and frame counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_sh          <= '0;
      o_sh          <= '0;
      win_sh        <= '0;
      cursor_en_sh  <= 1'b0;
      cursor_idx_sh <= 4'd0;
      frame_cnt     <= 5'd0;
    end else if (frame_tick) begin
      x_sh          <= x_matrix;
      o_sh          <= o_matrix;
      win_sh        <= win_mask;
      cursor_en_sh  <= cursor_en;
      cursor_idx_sh <= cursor_idx;
      frame_cnt     <= frame_cnt + 5'd1;
    end
  end

  // Two-stage pixel pipeline
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid    <= 1'b0;
      s1_in_glyph <= 1'b0;
      s1_win      <= 1'b0;
      s1_cursor   <= 1'b0;
      char_q      <= 7'd0;
      row_q       <= 4'd0;
      bit_q       <= 3'd0;
      xo_on       <= 1'b0;
      text_rgb    <= 3'b000;
    end else if (pixel_tick) begin
      s1_valid    <= 1'b1;
      s1_in_glyph <= in_glyph_c;
      s1_win      <= cell_w_c;
      s1_cursor   <= cursor_c;
      char_q      <= char_c;
      row_q       <= 4'(dy_c >> SCALE_SHIFT);
      bit_q       <= 3'(dx_c >> SCALE_SHIFT);
      xo_on       <= on_c;
      text_rgb    <= rgb_c;
    end
  end

`ifdef XO_GRID_LINES_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          s1_grid <= 1'b0;
    else if (pixel_tick) s1_grid <= grid_c;
  end
`endif

  assign font.char_addr = char_q;
  assign font.row_addr  = row_q;
  assign font.bit_addr  = bit_q;

endmodule

// File: tb/tb_xo_board_painter.sv
// Directed bench for xo_board_painter; expected pixels queued at drive time, checked at output.
module tb_xo_board_painter;

  logic       clk = 1'b0;
  logic       reset;
  logic       pixel_tick, frame_tick;
  logic [9:0] pix_x, pix_y;
  logic [8:0] x_matrix, o_matrix, win_mask;
  logic       cursor_en;
  logic [3:0] cursor_idx;
  logic       xo_on;
  logic [2:0] text_rgb;

  xo_board_painter_if font_if ();

  xo_board_painter dut (
    .clk        (clk),
    .reset      (reset),
    .pixel_tick (pixel_tick),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .frame_tick (frame_tick),
    .x_matrix   (x_matrix),
    .o_matrix   (o_matrix),
    .win_mask   (win_mask),
    .cursor_en  (cursor_en),
    .cursor_idx (cursor_idx),
    .font       (font_if),
    .xo_on      (xo_on),
    .text_rgb   (text_rgb)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] chr;
    logic       on;
    logic [2:0] rgb;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [4:0] fcnt = 5'd0;
  logic       co_frame = 1'b0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pixel_tick followed by a two-clock gap; optionally a coincident frame_tick
  task automatic tick(input logic [9:0] x, input logic [9:0] y, input logic fb);
    pix_x = x;
    pix_y = y;
    font_if.font_bit = fb;
    pixel_tick = 1'b1;
    if (co_frame) begin
      frame_tick = 1'b1;
      fcnt = fcnt + 5'd1;
    end
    @(posedge clk); #1;
    pixel_tick = 1'b0;
    frame_tick = 1'b0;
    co_frame = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    fcnt = fcnt + 5'd1;
  endtask

  task automatic step(input string tag, input logic [9:0] x, input logic [9:0] y, input logic fb,
                      input logic [6:0] chr, input logic on, input logic [2:0] rgb);
    exp_t e;
    e.chr = chr;
    e.on  = on;
    e.rgb = rgb;
    sb.push_back(e);
    tick(x, y, 1'b0);
    check({tag, "_char"}, 8'(font_if.char_addr), 8'(sb[0].chr));
    tick(10'd0, 10'd0, fb);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb observed empty expected entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_on"},  8'(xo_on),    8'(e.on));
      check({tag, "_rgb"}, 8'(text_rgb), 8'(e.rgb));
    end
  endtask

  initial begin
    reset = 1'b0;
    pixel_tick = 1'b0;
    frame_tick = 1'b0;
    pix_x = 10'd0;
    pix_y = 10'd0;
    font_if.font_bit = 1'b0;
    x_matrix = 9'd0;
    o_matrix = 9'd0;
    win_mask = 9'd0;
    cursor_en = 1'b0;
    cursor_idx = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_on",   8'(xo_on),             8'd0);
    check("rst_rgb",  8'(text_rgb),          8'd0);
    check("rst_char", 8'(font_if.char_addr), 8'd0);
    check("rst_row",  8'(font_if.row_addr),  8'd0);
    check("rst_bit",  8'(font_if.bit_addr),  8'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // X in cell 0; glyph, gap, and address decoding
    x_matrix = 9'b000000001;
    frame();
    step("x_cell0", 10'd192, 10'd384, 1'b1, 7'h58, 1'b1, 3'b111);
    step("x_gap",   10'd224, 10'd384, 1'b1, 7'h20, 1'b0, 3'b000);
    step("x_bg",    10'd212, 10'd400, 1'b0, 7'h58, 1'b1, 3'b000);
    tick(10'd212, 10'd400, 1'b0);
    check("row_addr", 8'(font_if.row_addr), 8'd4);
    check("bit_addr", 8'(font_if.bit_addr), 8'd5);
    tick(10'd0, 10'd0, 1'b0);
    step("off_left", 10'd100, 10'd400, 1'b1, 7'h20, 1'b0, 3'b000);

    // Mid-frame change is invisible until frame_tick
    x_matrix = 9'd0;
    step("no_tear", 10'd200, 10'd392, 1'b1, 7'h58, 1'b1, 3'b111);
    frame();
    step("after_ft", 10'd200, 10'd392, 1'b1, 7'h20, 1'b1, 3'b111);

    // Conflict and O glyphs
    x_matrix = 9'b000010000;
    o_matrix = 9'b100010000;
    frame();
    step("conflict", 10'd256, 10'd448, 1'b1, 7'h3F, 1'b1, 3'b111);
    step("o_cell8",  10'd320, 10'd512, 1'b1, 7'h4F, 1'b1, 3'b111);

    // Cursor on empty board: colours swapped
    x_matrix = 9'd0;
    o_matrix = 9'd0;
    cursor_en = 1'b1;
    cursor_idx = 4'd5;
    frame();
    step("cur_fb0",  10'd320, 10'd448, 1'b0, 7'h5F, 1'b1, 3'b111);
    step("cur_fb1",  10'd320, 10'd448, 1'b1, 7'h5F, 1'b1, 3'b000);
    step("cur_oth",  10'd256, 10'd448, 1'b0, 7'h20, 1'b1, 3'b000);
    cursor_idx = 4'd12;
    frame();
    step("cur_none", 10'd320, 10'd448, 1'b0, 7'h20, 1'b1, 3'b000);

    // Coincident pixel_tick and frame_tick use pre-capture board
    cursor_en = 1'b0;
    x_matrix = 9'b000000001;
    frame();
    x_matrix = 9'd0;
    co_frame = 1'b1;
    tick(10'd200, 10'd392, 1'b0);
    check("coinc_char", 8'(font_if.char_addr), 8'h58);
    step("coinc_next", 10'd200, 10'd392, 1'b1, 7'h20, 1'b1, 3'b111);

    // Win blink across a full 32-frame counter period
    x_matrix = 9'b100010001;
    win_mask = 9'b100010001;
    frame();
    for (int f = 0; f < 32; f++) begin
      step("win_c0", 10'd200, 10'd392, 1'b1, 7'h58, 1'b1, fcnt[4] ? 3'b010 : 3'b111);
      if (f % 8 == 0) begin
        step("win_c4", 10'd264, 10'd456, 1'b1, 7'h58, 1'b1, fcnt[4] ? 3'b010 : 3'b111);
        step("nowin_c1", 10'd264, 10'd392, 1'b1, 7'h20, 1'b1, 3'b111);
      end
      frame();
    end

    // Asynchronous reset mid-frame clears everything
    step("pre_rst", 10'd200, 10'd392, 1'b1, 7'h58, 1'b1, fcnt[4] ? 3'b010 : 3'b111);
    tick(10'd200, 10'd392, 1'b1);
    #3 reset = 1'b0;
    #1;
    check("mrst_on",   8'(xo_on),             8'd0);
    check("mrst_rgb",  8'(text_rgb),          8'd0);
    check("mrst_char", 8'(font_if.char_addr), 8'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    fcnt = 5'd0;
    win_mask = 9'd0;
    x_matrix = 9'b000000001;
    step("post_rst", 10'd200, 10'd392, 1'b1, 7'h20, 1'b1, 3'b111);
    frame();
    step("post_cap", 10'd200, 10'd392, 1'b1, 7'h58, 1'b1, 3'b111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
